muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle RV32M execution unit and its controller, sitting beside the single-cycle ALU in the EX stage.
- Accepts M-extension ops (SELECT 5'b01000..5'b01111) and runs radix-2 iterative shift-add multiply or restoring divide.
- Drives STALL to hold the pipeline until the result is ready.
- Handles RISC-V divide-by-zero and overflow as fast paths, and reuses the last division result for a DIV/REM pair on the same operands.

Parameters:
- WIDTH, 32, operand and result width; iteration count = WIDTH.
- REUSE_EN, 1, 1 enables the quotient/remainder reuse fast path.

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- START  input  1  EX-stage op request; held high by the pipeline while STALL is high.
- SELECT  input  5  ALU select code: 01000 MUL, 01001 MULH, 01010 MULHSU, 01011 MULHU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
- DATA1  input  WIDTH  rs1 operand.
- DATA2  input  WIDTH  rs2 operand.
- FLUSH  input  1  synchronous abort (branch/trap flush of EX).
- STALL  output  1  combinational; holds IF/ID/EX.
- VALID  output  1  one-cycle pulse, RESULT valid.
- RESULT  output  WIDTH  operation result.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - State=IDLE; counter, operand, accumulator and cache registers cleared; cache invalid.
  - Outputs: STALL=0, VALID=0, RESULT=0.
  - Asserting reset mid-operation aborts immediately; no VALID follows.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - START with SELECT[4:3]=2'b01: latch DATA1, DATA2 and SELECT.
  - Fast-path condition true -> DONE; multiply op -> MUL; divide op -> DIV.
  - Counter is cleared on the transition.
  - START with any other SELECT is ignored and STALL stays 0.
- Operand signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: DATA1 signed, DATA2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - DIV/REM: both signed.
  - Signed negative operands are converted to magnitudes at latch time; result sign = XOR of the operand signs (the remainder takes the dividend's sign).
- MUL: 2*WIDTH-bit shift-add, one multiplier bit per cycle for WIDTH cycles, then -> DONE.
- DIV: restoring divide, one quotient bit per cycle for WIDTH cycles, then -> DONE.
- DONE:
  - Sign correction applied combinationally.
  - VALID=1 and STALL=0 for exactly one cycle, then -> IDLE.
  - START is ignored in DONE (the same instruction is still presented).
  - RESULT holds its value until the next VALID.
- Result selection:
  - MUL: low WIDTH bits of the product.
  - MULH/MULHSU/MULHU: high WIDTH bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- STALL = (state==IDLE & START & M-op & ~FLUSH) | state==MUL | state==DIV.
- Latency: START accepted at cycle t -> VALID at t+WIDTH+1 (t+33).
  - Fast paths: VALID at t+1.
  - STALL is high for cycles t..VALID-1.
- Fast paths:
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> DATA1.
  - Signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF, DIV/REM): DIV -> 0x80000000; REM -> 0.
  - Reuse (REUSE_EN=1): cache valid, DATA1/DATA2 equal the cached operands, signedness matches, and the op is the complementary div/rem -> cached quotient/remainder.
  - Cache is written on every DIV-state completion; it is invalidated by reset, FLUSH, and any completion of a mul op.
- FLUSH:
  - FLUSH in any state -> IDLE next cycle, no VALID, cache invalidated.
  - FLUSH with START in IDLE: the request is not accepted.
  - FLUSH in DONE suppresses VALID.
- Back-to-back ops: the next op is accepted in the cycle after DONE; there is no extra bubble.

Test Plan:
- MUL DATA1=7, DATA2=0xFFFFFFFD (-3) -> STALL high 33 cycles, VALID at t+33, RESULT=0xFFFFFFEB; next-cycle MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD at t+33; then REM on the same operands -> 0xFFFFFFFF at t+1 via reuse; then REMU on the same operands -> full 33-cycle run, RESULT=1.
- DIVU 5/0 -> 0xFFFFFFFF at t+1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at t+1.
- DIV in flight, FLUSH at t+10 -> STALL 0 at t+11, no VALID, state IDLE; a following REM on the same operands takes 33 cycles (cache cleared).
- RESET_N low at t+5 of a MUL -> STALL/VALID/RESULT 0 immediately; a new op after release completes normally; START with SELECT=00000 -> STALL 0, no VALID.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply / restoring divide, WIDTH+1 cycles (fast paths 1).
// STALL holds the pipeline from acceptance until the VALID cycle; FLUSH aborts with no VALID.
module muldiv_sequencer #(
  parameter int WIDTH    = 32,
  parameter bit REUSE_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [4:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             FLUSH,
  output logic             STALL,
  output logic             VALID,
  output logic [WIDTH-1:0] RESULT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic               neg_q, neg_r, fast;
  logic [WIDTH-1:0]   fast_res, result_q;
  logic               c_vld, c_signed, c_rem;
  logic [WIDTH-1:0]   c_d1, c_d2;

  logic             m_op, is_div, sgn1_en, sgn2_en, neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2, fast_val;
  logic             div_zero, div_ovf, reuse, fast_hit, accept, last;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, final_res;

  assign m_op    = (SELECT[4:3] == 2'b01);
  assign is_div  = SELECT[2];
  assign sgn1_en = SELECT[2] ? ~SELECT[0] : (SELECT[1:0] != 2'b11);
  assign sgn2_en = SELECT[2] ? ~SELECT[0] : ~SELECT[1];
  assign neg1    = sgn1_en & DATA1[WIDTH-1];
  assign neg2    = sgn2_en & DATA2[WIDTH-1];
  assign mag1    = neg1 ? (~DATA1 + 1'b1) : DATA1;
  assign mag2    = neg2 ? (~DATA2 + 1'b1) : DATA2;

  assign div_zero = is_div & (DATA2 == '0);
  assign div_ovf  = is_div & ~SELECT[0] & (DATA1 == MIN_NEG) & (DATA2 == ALL_ONE);
  // Complementary op on identical operands/signedness: the cached acc already holds both answers.
  assign reuse    = REUSE_EN & c_vld & is_div & (DATA1 == c_d1) & (DATA2 == c_d2)
                  & (c_signed == ~SELECT[0]) & (c_rem != SELECT[1]);
  assign fast_hit = div_zero | div_ovf | reuse;
  assign fast_val = div_zero ? (SELECT[1] ? DATA1 : ALL_ONE) : (SELECT[1] ? '0 : MIN_NEG);
  assign accept   = (state == S_IDLE) & START & m_op & ~FLUSH;
  assign last     = (cnt == CW'(WIDTH - 1));

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb};
  assign div_ok   = ~div_diff[WIDTH];

  assign prod = neg_q ? (~acc + 1'b1) : acc;
  assign quo  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    final_res = '0;
    if (fast)
      final_res = fast_res;
    else if (op[2])
      final_res = op[1] ? rem : quo;
    else
      final_res = (op[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  assign VALID  = (state == S_DONE) & ~FLUSH;
  assign RESULT = VALID ? final_res : result_q;
  assign STALL  = (accept & RESET_N) | (state == S_MUL) | (state == S_DIV);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op       <= '0;
      opb      <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      fast     <= 1'b0;
      fast_res <= '0;
      result_q <= '0;
      c_vld    <= 1'b0;
      c_signed <= 1'b0;
      c_rem    <= 1'b0;
      c_d1     <= '0;
      c_d2     <= '0;
    end else if (FLUSH) begin
      state <= S_IDLE;
      c_vld <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START && m_op) begin
            op       <= SELECT[2:0];
            neg_q    <= neg1 ^ neg2;
            neg_r    <= neg1;
            fast     <= div_zero | div_ovf;
            fast_res <= fast_val;
            cnt      <= '0;
            if (fast_hit) begin
              state <= S_DONE;
            end else begin
              // acc is only reloaded here so a fast path never clobbers the cached quotient/remainder.
              acc   <= {{WIDTH{1'b0}}, mag1};
              opb   <= mag2;
              c_vld <= 1'b0;
              if (is_div) begin
                state    <= S_DIV;
                c_d1     <= DATA1;
                c_d2     <= DATA2;
                c_signed <= ~SELECT[0];
                c_rem    <= SELECT[1];
              end else begin
                state <= S_MUL;
              end
            end
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (last) state <= S_DONE;
        end
        S_DIV: begin
          acc <= {div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0], acc[WIDTH-2:0], div_ok};
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= S_DONE;
            c_vld <= 1'b1;
          end
        end
        default: begin
          result_q <= final_res;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed RV32M cases plus randomized ops with flushes,
// checked every cycle against an arithmetic reference model with its own reuse-cache bookkeeping.
module tb_muldiv_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N, START, FLUSH;
  logic [4:0]  SELECT;
  logic [31:0] DATA1, DATA2;
  logic        STALL, VALID;
  logic [31:0] RESULT;

  always #5 CLK = ~CLK;

  muldiv_sequencer #(.WIDTH(32), .REUSE_EN(1'b1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
    .STALL(STALL), .VALID(VALID), .RESULT(RESULT)
  );

  localparam logic [4:0] MUL = 5'b01000, MULH = 5'b01001, MULHSU = 5'b01010, MULHU = 5'b01011;
  localparam logic [4:0] DIV = 5'b01100, DIVU = 5'b01101, REM = 5'b01110, REMU = 5'b01111;

  int          n_chk = 0, n_fail = 0;
  bit          chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_valid = 1'b0;
  logic [31:0] exp_result = '0;

  // Model of the reuse cache: last full divide run
  bit          c_vld = 1'b0, c_signed = 1'b0, c_rem = 1'b0;
  logic [31:0] c_d1 = '0, c_d2 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("stall", {31'b0, STALL}, {31'b0, exp_stall});
      check("valid", {31'b0, VALID}, {31'b0, exp_valid});
      check("result", RESULT, exp_result);
    end
  end

  function automatic logic [31:0] ref_result(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = int'(a);
    ib = int'(b);
    case (sel[2:0])
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive(input bit st, input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b, input bit fl);
    @(posedge CLK);
    #1;
    START  = st;
    SELECT = sel;
    DATA1  = a;
    DATA2  = b;
    FLUSH  = fl;
  endtask

  // One op as the pipeline presents it; flush_at = cycle offset of a FLUSH pulse (-1 for none).
  task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input bit use_lit, input logic [31:0] lit, input int lit_lat);
    logic [31:0] res;
    bit          sgn, fast;
    int          lat;
    res  = ref_result(sel, a, b);
    sgn  = ~sel[0];
    fast = sel[2] && (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                      (c_vld && a == c_d1 && b == c_d2 && c_signed == sgn && c_rem != sel[1]));
    lat  = fast ? 1 : 33;
    if (use_lit) begin
      check("model_result", res, lit);
      check("model_latency", 32'(lat), 32'(lit_lat));
    end
    for (int k = 0; k <= lat; k++) begin
      drive(1'b1, sel, a, b, k == flush_at);
      if (k == flush_at) begin
        exp_stall = (k > 0 && k < lat);
        exp_valid = 1'b0;
        c_vld     = 1'b0;
        drive(1'b0, 5'b0, a, b, 1'b0);
        exp_stall = 1'b0;
        exp_valid = 1'b0;
        return;
      end
      exp_stall = (k < lat);
      exp_valid = (k == lat);
      if (k == lat) exp_result = res;
    end
    if (!sel[2]) begin
      c_vld = 1'b0;
    end else if (!fast) begin
      c_vld = 1'b1; c_d1 = a; c_d2 = b; c_signed = sgn; c_rem = sel[1];
    end
  endtask

  task automatic idle(input int n, input bit st, input logic [4:0] sel);
    repeat (n) begin
      drive(st, sel, $urandom, $urandom, 1'b0);
      exp_stall = 1'b0;
      exp_valid = 1'b0;
    end
  endtask

  task automatic reset_mid(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b, input int at);
    for (int k = 0; k < at; k++) begin
      drive(1'b1, sel, a, b, 1'b0);
      exp_stall = 1'b1;
      exp_valid = 1'b0;
    end
    @(posedge CLK);
    #1;
    RESET_N    = 1'b0;
    exp_stall  = 1'b0;
    exp_valid  = 1'b0;
    exp_result = '0;
    c_vld      = 1'b0;
    #1;
    check("rst_stall", {31'b0, STALL}, 32'd0);
    check("rst_valid", {31'b0, VALID}, 32'd0);
    check("rst_result", RESULT, 32'd0);
    drive(1'b0, 5'b0, 32'd0, 32'd0, 1'b0);
    RESET_N = 1'b1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'(0 - $urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0]  rs;
  logic [31:0] ra, rb, pa, pb;
  int          rf;

  initial begin
    RESET_N = 1'b0; START = 1'b0; FLUSH = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
    pa = 32'd3; pb = 32'd5;
    chk_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;

    run_op(MUL,    32'd7,        32'hFFFF_FFFD, -1, 1'b1, 32'hFFFF_FFEB, 33);
    run_op(MULH,   32'h8000_0000, 32'h8000_0000, -1, 1'b1, 32'h4000_0000, 33);
    run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1, 32'hFFFF_FFFF, 33);
    run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1, 32'hFFFF_FFFE, 33);
    run_op(DIV,    32'hFFFF_FFF9, 32'd2,         -1, 1'b1, 32'hFFFF_FFFD, 33);
    run_op(REM,    32'hFFFF_FFF9, 32'd2,         -1, 1'b1, 32'hFFFF_FFFF, 1);
    run_op(REMU,   32'hFFFF_FFF9, 32'd2,         -1, 1'b1, 32'h0000_0001, 33);
    run_op(DIVU,   32'd5,         32'd0,         -1, 1'b1, 32'hFFFF_FFFF, 1);
    run_op(REM,    32'd5,         32'd0,         -1, 1'b1, 32'd5,         1);
    run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1, 32'h8000_0000, 1);
    run_op(DIVU,   32'hFFFF_FFF9, 32'd2,         -1, 1'b1, 32'h7FFF_FFFC, 1);
    idle(2, 1'b0, 5'b0);
    run_op(DIV,    32'd100,       32'd7,         10, 1'b0, 32'd0,         0);
    run_op(REM,    32'd100,       32'd7,         -1, 1'b1, 32'd2,         33);
    reset_mid(MUL, 32'd12345, 32'd678, 5);
    run_op(MUL,    32'd6,         32'd7,         -1, 1'b1, 32'd42,        33);
    idle(3, 1'b1, 5'b00000);
    idle(2, 1'b1, 5'b11000);

    for (int i = 0; i < 120; i++) begin
      rs = MUL | 5'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        ra = pa; rb = pb;
      end else begin
        ra = rand_operand(); rb = rand_operand();
      end
      rf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 34)) : -1;
      run_op(rs, ra, rb, rf, 1'b0, 32'd0, 0);
      pa = ra; pb = rb;
      if ($urandom_range(0, 7) == 0) idle(1, 1'b1, 5'($urandom_range(0, 7)));
    end

    idle(2, 1'b0, 5'b0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
